// File: rtl/txwords_mux.sv
// Round-robin multi-channel hex line formatter feeding an integrated
// 8N1 UART transmitter; one holding buffer per channel.
module txwords_mux #(
    parameter int NCH             = 4,
    parameter int DW              = 32,
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int CRLF            = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NCH-1:0]    i_stb,
    input  logic [NCH*DW-1:0] i_data,
    output logic [NCH-1:0]    o_pending,
    output logic [NCH-1:0]    o_overrun,
    output logic              o_busy,
    output logic              o_uart_tx
);
    localparam int ND  = DW / 4;
    localparam int LEN = ND + 3 + CRLF;
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW  = $clog2(CLOCKS_PER_BAUD);

    localparam logic [3:0]    DIG_END  = 4'(ND + 2);
    localparam logic [3:0]    LINE_END = 4'(LEN);
    localparam logic [3:0]    STOP_BIT = 4'd9;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLOCKS_PER_BAUD - 1);
    localparam logic [PW-1:0] LAST_CH  = PW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        CHAR,
        DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] buffer [NCH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] pick;
    logic [PW-1:0] chan;
    logic          found;
    logic [DW-1:0] word;
    logic          flag;
    logic [3:0]    cidx;
    logic [3:0]    bidx;
    logic [BW-1:0] cnt;
    logic [9:0]    frame;
    logic [7:0]    next_char;
    logic          grant;
    logic          bit_end;
    logic          load;
    logic          line_end;

    assign o_uart_tx = frame[0];

    // First pending channel at or after the pointer, wrapping.
    always_comb begin
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr) + i;
            if (j >= NCH)
                j = j - NCH;
            if (!found && o_pending[PW'(j)]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    assign grant    = ((state == IDLE) || (state == DONE)) && found;
    assign bit_end  = (state == CHAR) && (cnt == '0);
    assign line_end = bit_end && (bidx == STOP_BIT) &&
                      (cidx == LINE_END);
    assign load     = (state == GRANT) ||
                      (bit_end && (bidx == STOP_BIT) &&
                       (cidx != LINE_END));

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n})
                           : (8'h57 + {4'h0, n});
    endfunction

    // cidx names the character that the next load will put on the wire.
    always_comb begin
        next_char = 8'h0a;
        if (cidx == 4'd0)
            next_char = hex_char(4'(chan));
        else if (cidx == 4'd1)
            next_char = flag ? 8'h21 : 8'h3a;
        else if (cidx < DIG_END)
            next_char = hex_char(word[DW-1 -: 4]);
        else if ((CRLF != 0) && (cidx == DIG_END))
            next_char = 8'h0d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            chan      <= '0;
            word      <= '0;
            flag      <= 1'b0;
            cidx      <= '0;
            bidx      <= '0;
            cnt       <= '0;
            frame     <= '1;
            o_busy    <= 1'b0;
            o_pending <= '0;
            o_overrun <= '0;
            for (int k = 0; k < NCH; k++)
                buffer[k] <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    state <= grant ? GRANT : IDLE;
                    if (grant) begin
                        word            <= buffer[pick];
                        chan            <= pick;
                        flag            <= o_overrun[pick];
                        o_overrun[pick] <= 1'b0;
                        o_pending[pick] <= 1'b0;
                        o_busy          <= 1'b1;
                        cidx            <= '0;
                        ptr             <= (pick == LAST_CH) ? '0
                                           : pick + PW'(1);
                    end
                end
                GRANT: begin
                    state <= CHAR;
                end
                CHAR: begin
                    if (line_end) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Serialiser: frame shifts right, ones fill behind the stop bit.
            if (load) begin
                frame <= {1'b1, next_char, 1'b0};
                cidx  <= cidx + 4'd1;
                bidx  <= '0;
                cnt   <= BAUD_MAX;
                if ((cidx >= 4'd2) && (cidx < DIG_END))
                    word <= word << 4;
            end else if (bit_end) begin
                cnt <= BAUD_MAX;
                if (bidx != STOP_BIT) begin
                    frame <= {1'b1, frame[9:1]};
                    bidx  <= bidx + 4'd1;
                end
            end else if (state == CHAR) begin
                cnt <= cnt - BW'(1);
            end

            // Capture runs last so a strobe wins over the grant clear.
            for (int k = 0; k < NCH; k++) begin
                if (i_stb[k]) begin
                    buffer[k]    <= i_data[k*DW +: DW];
                    o_pending[k] <= 1'b1;
                    if (o_pending[k] && !(grant && (pick == PW'(k))))
                        o_overrun[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_txwords_mux.sv
// Scoreboard bench for txwords_mux: both serial lines are decoded and
// every character is compared against queued expected lines.
module tb_txwords_mux;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   stb_a;
    logic [127:0] data_a;
    logic [3:0]   pend_a;
    logic [3:0]   ovr_a;
    logic         busy_a;
    logic         tx_a;
    logic         stb_b;
    logic [7:0]   data_b;
    logic         pend_b;
    logic         ovr_b;
    logic         busy_b;
    logic         tx_b;

    int         checks = 0;
    int         errors = 0;
    bit         mute   = 1'b0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    string      hx = "0123456789abcdef";

    txwords_mux #(
        .NCH(4), .DW(32), .CLOCKS_PER_BAUD(4), .CRLF(1)
    ) dut_a (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_stb(stb_a),
        .i_data(data_a),
        .o_pending(pend_a),
        .o_overrun(ovr_a),
        .o_busy(busy_a),
        .o_uart_tx(tx_a)
    );

    txwords_mux #(
        .NCH(1), .DW(8), .CLOCKS_PER_BAUD(4), .CRLF(0)
    ) dut_b (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_stb(stb_b),
        .i_data(data_b),
        .o_pending(pend_b),
        .o_overrun(ovr_b),
        .o_busy(busy_b),
        .o_uart_tx(tx_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic push_line(input int w, input int ch,
                             input logic [7:0] fl,
                             input logic [31:0] d, input int nd,
                             input bit crlf);
        logic [7:0] c[$];
        c.push_back(hx[ch]);
        c.push_back(fl);
        for (int i = nd - 1; i >= 0; i--)
            c.push_back(hx[int'((d >> (4 * i)) & 32'hf)]);
        if (crlf)
            c.push_back(8'h0d);
        c.push_back(8'h0a);
        foreach (c[i]) begin
            if (w == 0)
                q_a.push_back(c[i]);
            else
                q_b.push_back(c[i]);
        end
    endtask

    function automatic logic txv(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    // UART receiver: sample each bit mid-way, 4 clocks per bit.
    task automatic mon(input int w);
        logic [7:0] b;
        logic [7:0] e;
        logic       stop;
        forever begin
            @(negedge clk);
            if (rst_n && (txv(w) == 1'b0)) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = txv(w);
                end
                repeat (4) @(negedge clk);
                stop = txv(w);
                if (!mute) begin
                    chk($sformatf("stop%0d", w), 32'(stop), 32'd1);
                    checks++;
                    if ((w == 0 && q_a.size() == 0) ||
                        (w == 1 && q_b.size() == 0)) begin
                        errors++;
                        $display("FAIL char%0d: got %02h required none",
                                 w, b);
                    end else begin
                        e = (w == 0) ? q_a.pop_front() : q_b.pop_front();
                        if (b !== e) begin
                            errors++;
                            $display("FAIL char%0d: got %02h required %02h",
                                     w, b, e);
                        end
                    end
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    task automatic drain(input int w, input int budget);
        int n;
        n = 0;
        while (n < budget &&
               ((w == 0) ? (q_a.size() != 0 || busy_a)
                         : (q_b.size() != 0 || busy_b))) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain%0d", w), 32'(n < budget), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic strobe_a(input logic [3:0] m, input logic [127:0] d);
        @(negedge clk);
        stb_a  = m;
        data_a = d;
        @(negedge clk);
        stb_a = '0;
    endtask

    initial begin
        int   n;
        logic lo;
        rst_n  = 1'b0;
        stb_a  = '0;
        data_a = '0;
        stb_b  = 1'b0;
        data_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_pend", 32'(pend_a), 32'd0);
        chk("rst_ovr", 32'(ovr_a), 32'd0);
        chk("rst_tx_b", 32'(tx_b), 32'd1);
        rst_n = 1'b1;
        lo = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (!tx_a || !tx_b)
                lo = 1'b1;
        end
        chk("idle_high", 32'(lo), 32'd0);

        push_line(0, 2, 8'h3a, 32'h12ab09ff, 8, 1);
        strobe_a(4'b0100, {32'h0, 32'h12ab09ff, 64'h0});
        chk("cap_pend", 32'(pend_a), 32'h4);
        @(negedge clk);
        chk("grant_busy", 32'(busy_a), 32'd1);
        chk("grant_tx", 32'(tx_a), 32'd1);
        chk("grant_pend", 32'(pend_a), 32'd0);
        @(negedge clk);
        chk("start_bit", 32'(tx_a), 32'd0);
        n = 0;
        while (busy_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("line_cycles", 32'(n), 32'd480);
        drain(0, 100);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_line(0, 0, 8'h3a, 32'hdeadbeef, 8, 1);
        push_line(0, 1, 8'h3a, 32'h00000001, 8, 1);
        push_line(0, 3, 8'h3a, 32'hcafef00d, 8, 1);
        strobe_a(4'b1011,
                 {32'hcafef00d, 32'h0, 32'h00000001, 32'hdeadbeef});
        chk("rr_pend", 32'(pend_a), 32'hb);
        drain(0, 2000);
        push_line(0, 0, 8'h3a, 32'h0000abcd, 8, 1);
        push_line(0, 3, 8'h3a, 32'h89abcdef, 8, 1);
        strobe_a(4'b1001, {32'h89abcdef, 64'h0, 32'h0000abcd});
        drain(0, 1500);

        push_line(0, 0, 8'h3a, 32'h55aa55aa, 8, 1);
        strobe_a(4'b0001, {96'h0, 32'h55aa55aa});
        repeat (10) @(negedge clk);
        strobe_a(4'b0010, {64'h0, 32'h1, 32'h0});
        chk("ovr_first", 32'(ovr_a), 32'd0);
        strobe_a(4'b0010, {64'h0, 32'h2, 32'h0});
        chk("ovr_set", 32'(ovr_a), 32'h2);
        chk("ovr_pend", 32'(pend_a), 32'h2);
        push_line(0, 1, 8'h21, 32'h00000002, 8, 1);
        drain(0, 1500);
        chk("ovr_clr", 32'(ovr_a), 32'd0);

        push_line(0, 0, 8'h3a, 32'h0badf00d, 8, 1);
        push_line(0, 0, 8'h3a, 32'h600dcafe, 8, 1);
        strobe_a(4'b0001, {96'h0, 32'h0badf00d});
        stb_a  = 4'b0001;
        data_a = {96'h0, 32'h600dcafe};
        @(negedge clk);
        stb_a = '0;
        chk("regrant_pend", 32'(pend_a), 32'h1);
        chk("regrant_ovr", 32'(ovr_a), 32'd0);
        drain(0, 1500);

        mute = 1'b1;
        strobe_a(4'b1100, {32'h0fedcba9, 32'h12345678, 64'h0});
        repeat (162) @(negedge clk);
        chk("mid_tx", 32'(tx_a), 32'd0);
        chk("mid_pend", 32'(pend_a), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(tx_a), 32'd1);
        chk("abort_pend", 32'(pend_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lo = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (!tx_a)
                lo = 1'b1;
        end
        chk("post_abort_idle", 32'(lo), 32'd0);
        chk("post_abort_pend", 32'(pend_a), 32'd0);
        q_a.delete();
        mute = 1'b0;

        push_line(1, 0, 8'h3a, 32'h7e, 2, 0);
        @(negedge clk);
        stb_b  = 1'b1;
        data_b = 8'h7e;
        @(negedge clk);
        stb_b = 1'b0;
        chk("b_pend", 32'(pend_b), 32'd1);
        @(negedge clk);
        chk("b_busy", 32'(busy_b), 32'd1);
        @(negedge clk);
        chk("b_start", 32'(tx_b), 32'd0);
        n = 0;
        while (busy_b && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("b_line_cycles", 32'(n), 32'd200);
        drain(1, 100);
        chk("b_ovr", 32'(ovr_b), 32'd0);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
